// File: rtl/eth_pkg.sv
// Shared Ethernet receive/transmit definitions.
//   - RMII preamble / SFD dibit values
//   - CRC-32 polynomial (normal and reflected) and the good-frame residue
//   - receive FSM state encoding
package eth_pkg;

  localparam logic [1:0]  ETH_PRE_DIBIT   = 2'b01;
  localparam logic [1:0]  ETH_SFD_DIBIT   = 2'b11;

  localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  // Register value after running data + FCS through the reflected CRC.
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAM,
    ST_DATA,
    ST_DROP,
    ST_EOF
  } rx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide reflected CRC-32 next-state function.
// Bytes are consumed LSB first, as they appear on the wire.
//   i_crc  : current CRC register
//   i_data : byte to fold in
//   o_crc  : CRC register after the byte
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  always_comb begin
    logic [31:0] v_c;
    v_c = i_crc ^ {24'h0, i_data};
    for (int unsigned i = 0; i < 8; i++) begin
      v_c = v_c[0] ? ((v_c >> 1) ^ CRC32_POLY_REFL) : (v_c >> 1);
    end
    o_crc = v_c;
  end

endmodule

// File: rtl/rmii_recv_pack.sv
// RMII receive path: strips preamble/SFD, packs dibits into bytes, streams
// them out with frame markers and reports end-of-frame status.
//   clk, rst         : 50 MHz RMII reference clock, async active-high reset
//   PhyRxd/PhyCrsDv/PhyRxEr : PHY receive pins (registered once on entry)
//   rx_data/rx_valid/rx_sof : byte stream, DA..FCS
//   rx_eof           : 1-cycle end-of-frame strobe
//   rx_len/rx_crc_ok/rx_err : frame status, updated at rx_eof and held
//   rx_err = {phy_err, align_err, long_err, short_err}
module rmii_recv_pack
  import eth_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       PhyRxd,
  input  logic             PhyCrsDv,
  input  logic             PhyRxEr,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_sof,
  output logic             rx_eof,
  output logic [LEN_W-1:0] rx_len,
  output logic             rx_crc_ok,
  output logic [3:0]       rx_err
);

  logic [1:0]       r_rxd;
  logic             r_crs;
  logic             r_rxer;

  rx_state_t        r_state;
  rx_state_t        w_next;

  logic [1:0]       r_phase;
  logic [5:0]       r_shift;
  logic [LEN_W-1:0] r_cnt;
  logic [31:0]      r_crc;
  logic             r_sof_pend;
  logic             r_phy_err;
  logic             r_long;

  logic [7:0]       w_byte;
  logic [31:0]      w_crc_next;
  logic [LEN_W-1:0] w_cnt_inc;

  logic             w_start;
  logic             w_take;
  logic             w_byte_done;
  logic             w_emit;
  logic             w_long;
  logic             w_eof;
  logic             w_align;
  logic             w_err_chk;

  // New dibit enters at the MSB; after four dibits the byte is complete.
  assign w_byte    = {r_rxd, r_shift};
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  crc32_d8 u_crc (
    .i_crc  (r_crc),
    .i_data (w_byte),
    .o_crc  (w_crc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxd  <= '0;
      r_crs  <= 1'b0;
      r_rxer <= 1'b0;
    end else begin
      r_rxd  <= PhyRxd;
      r_crs  <= PhyCrsDv;
      r_rxer <= PhyRxEr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_take      = 1'b0;
    w_byte_done = 1'b0;
    w_emit      = 1'b0;
    w_long      = 1'b0;
    w_eof       = 1'b0;
    w_align     = 1'b0;
    w_err_chk   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_crs && r_rxd == ETH_PRE_DIBIT) begin
          w_next  = ST_PREAM;
          w_start = 1'b1;
        end
      end
      ST_PREAM: begin
        if (r_crs && r_rxd == ETH_PRE_DIBIT)      w_next = ST_PREAM;
        else if (r_crs && r_rxd == ETH_SFD_DIBIT) w_next = ST_DATA;
        else                                      w_next = ST_IDLE;
      end
      ST_DATA: begin
        if (!r_crs) begin
          w_next  = ST_EOF;
          w_eof   = 1'b1;
          w_align = (r_phase != 2'd0);
        end else begin
          w_take    = 1'b1;
          w_err_chk = 1'b1;
          if (r_phase == 2'd3) begin
            w_byte_done = 1'b1;
            // The byte that pushes the count past MAX_LEN is counted but
            // not emitted; everything after it is discarded in DROP.
            if (w_cnt_inc == LEN_W'(MAX_LEN + 1)) begin
              w_long = 1'b1;
              w_next = ST_DROP;
            end else begin
              w_emit = 1'b1;
            end
          end
        end
      end
      ST_DROP: begin
        if (!r_crs) begin
          w_next = ST_EOF;
          w_eof  = 1'b1;
        end else begin
          w_err_chk = 1'b1;
        end
      end
      ST_EOF:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase    <= '0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_crc      <= CRC32_INIT;
      r_sof_pend <= 1'b0;
      r_phy_err  <= 1'b0;
      r_long     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_sof     <= 1'b0;
      rx_eof     <= 1'b0;
      rx_len     <= '0;
      rx_crc_ok  <= 1'b0;
      rx_err     <= '0;
    end else begin
      rx_valid <= w_emit;
      rx_sof   <= w_emit && r_sof_pend;
      rx_eof   <= w_eof;
      if (w_emit) begin
        rx_data    <= w_byte;
        r_sof_pend <= 1'b0;
      end

      if (w_start) begin
        r_phase    <= '0;
        r_cnt      <= '0;
        r_crc      <= CRC32_INIT;
        r_sof_pend <= 1'b1;
        r_phy_err  <= 1'b0;
        r_long     <= 1'b0;
      end

      if (w_err_chk && r_rxer) r_phy_err <= 1'b1;

      if (w_take) begin
        r_shift <= w_byte[7:2];
        r_phase <= r_phase + 2'd1;
      end

      if (w_byte_done) begin
        r_crc <= w_crc_next;
        r_cnt <= w_cnt_inc;
        if (w_long) r_long <= 1'b1;
      end

      if (w_eof) begin
        rx_len    <= r_cnt;
        rx_crc_ok <= (r_crc == CRC32_RESIDUE);
        rx_err    <= {r_phy_err, w_align, r_long, (r_cnt < LEN_W'(MIN_LEN))};
      end
    end
  end

endmodule

// File: tb/tb_rmii_recv_pack.sv
module tb_rmii_recv_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  PhyRxd = '0;
  logic        PhyCrsDv = 1'b0;
  logic        PhyRxEr = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_eof;
  logic [15:0] rx_len;
  logic        rx_crc_ok;
  logic [3:0]  rx_err;

  rmii_recv_pack #(
    .MIN_LEN (64),
    .MAX_LEN (1518),
    .LEN_W   (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .PhyRxd    (PhyRxd),
    .PhyCrsDv  (PhyCrsDv),
    .PhyRxEr   (PhyRxEr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_sof    (rx_sof),
    .rx_eof    (rx_eof),
    .rx_len    (rx_len),
    .rx_crc_ok (rx_crc_ok),
    .rx_err    (rx_err)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] frame [0:1599];
  logic [7:0] cap   [0:8191];

  int n_valid = 0;
  int n_sof   = 0;
  int sof_idx = -1;
  int n_eof   = 0;
  int n_ok    = 0;
  logic [15:0] e_len = '0;
  logic        e_ok  = 1'b0;
  logic [3:0]  e_err = '0;

  always @(negedge clk) begin
    if (rx_valid) begin
      if (rx_sof) begin
        n_sof   = n_sof + 1;
        sof_idx = n_valid;
      end
      if (n_valid < 8192) cap[n_valid] = rx_data;
      n_valid = n_valid + 1;
    end
    if (rx_eof) begin
      n_eof = n_eof + 1;
      if (rx_crc_ok) n_ok = n_ok + 1;
      e_len = rx_len;
      e_ok  = rx_crc_ok;
      e_err = rx_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0d (0x%0h) want=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic drive(input logic [1:0] d, input logic crs, input logic er);
    @(negedge clk);
    PhyRxd   = d;
    PhyCrsDv = crs;
    PhyRxEr  = er;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic er);
    for (int k = 0; k < 4; k++) drive(b[2*k +: 2], 1'b1, er);
  endtask

  task automatic send_preamble();
    for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0);
    send_byte(8'hD5, 1'b0);
  endtask

  task automatic send_bytes(input int n, input int err_at);
    for (int i = 0; i < n; i++) send_byte(frame[i], (i == err_at));
  endtask

  // Bit-serial reference CRC over frame[0..n-1].
  function automatic logic [31:0] crc_ref(input int n);
    logic [31:0] c;
    logic        fb;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      b = frame[i];
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  // n bytes total, last four are the FCS sent LSB byte first.
  task automatic build(input int n);
    logic [31:0] f;
    for (int i = 0; i < n - 4; i++) frame[i] = 8'((i * 37 + 11) ^ (i >> 3));
    f = ~crc_ref(n - 4);
    frame[n-4] = f[7:0];
    frame[n-3] = f[15:8];
    frame[n-2] = f[23:16];
    frame[n-1] = f[31:24];
  endtask

  function automatic int data_mism(input int base, input int n);
    int m = 0;
    for (int i = 0; i < n; i++) if (cap[base + i] !== frame[i]) m++;
    return m;
  endfunction

  int v0, s0, e0, k0;

  initial begin
    // Reset state
    idle(3);
    chk("rst_data",   32'(rx_data), 0);
    chk("rst_flags",  32'({rx_valid, rx_sof, rx_eof, rx_crc_ok}), 0);
    chk("rst_len",    32'(rx_len), 0);
    chk("rst_err",    32'(rx_err), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    // 1: good 64-byte frame
    build(64);
    v0 = n_valid; s0 = n_sof; e0 = n_eof;
    send_preamble(); send_bytes(64, -1); idle(8);
    chk("t1_valid", 32'(n_valid - v0), 64);
    chk("t1_sof",   32'(n_sof - s0), 1);
    chk("t1_sofpos", 32'(sof_idx - v0), 0);
    chk("t1_data",  32'(data_mism(v0, 64)), 0);
    chk("t1_eof",   32'(n_eof - e0), 1);
    chk("t1_len",   32'(e_len), 64);
    chk("t1_ok",    32'(e_ok), 1);
    chk("t1_err",   32'(e_err), 0);
    chk("t1_hold_len", 32'(rx_len), 64);

    // 2: one payload bit flipped
    frame[20] = frame[20] ^ 8'h10;
    e0 = n_eof;
    send_preamble(); send_bytes(64, -1); idle(8);
    chk("t2_eof", 32'(n_eof - e0), 1);
    chk("t2_ok",  32'(e_ok), 0);
    chk("t2_err", 32'(e_err), 0);
    chk("t2_len", 32'(e_len), 64);

    // 3a: short frame with good CRC
    build(60);
    e0 = n_eof;
    send_preamble(); send_bytes(60, -1); idle(8);
    chk("t3_eof", 32'(n_eof - e0), 1);
    chk("t3_ok",  32'(e_ok), 1);
    chk("t3_err", 32'(e_err), 1);
    chk("t3_len", 32'(e_len), 60);

    // 3b: 1600-byte frame: 1518 emitted, 1519th counted, rest dropped
    build(1600);
    v0 = n_valid; e0 = n_eof;
    send_preamble(); send_bytes(1600, -1); idle(8);
    chk("t3l_valid", 32'(n_valid - v0), 1518);
    chk("t3l_data",  32'(data_mism(v0, 1518)), 0);
    chk("t3l_eof",   32'(n_eof - e0), 1);
    chk("t3l_err",   32'(e_err), 2);
    chk("t3l_len",   32'(e_len), 1519);

    // 4a: CRS_DV drops two dibits into byte 70
    build(80);
    v0 = n_valid; e0 = n_eof;
    send_preamble(); send_bytes(70, -1);
    drive(frame[70][1:0], 1'b1, 1'b0);
    drive(frame[70][3:2], 1'b1, 1'b0);
    idle(8);
    chk("t4_valid", 32'(n_valid - v0), 70);
    chk("t4_eof",   32'(n_eof - e0), 1);
    chk("t4_err",   32'(e_err), 4);
    chk("t4_len",   32'(e_len), 70);

    // 4b: PHY error mid-frame, data itself intact
    build(64);
    e0 = n_eof;
    send_preamble(); send_bytes(64, 30); idle(8);
    chk("t4e_eof", 32'(n_eof - e0), 1);
    chk("t4e_err", 32'(e_err), 8);
    chk("t4e_ok",  32'(e_ok), 1);

    // 5a: corrupted SFD tail -> nothing reported
    v0 = n_valid; e0 = n_eof;
    for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0);
    drive(2'b01, 1'b1, 1'b0); drive(2'b01, 1'b1, 1'b0);
    drive(2'b01, 1'b1, 1'b0); drive(2'b10, 1'b1, 1'b0);
    idle(8);
    chk("t5_valid", 32'(n_valid - v0), 0);
    chk("t5_eof",   32'(n_eof - e0), 0);

    // 5b: back-to-back frames, one idle dibit between
    v0 = n_valid; e0 = n_eof; k0 = n_ok;
    send_preamble(); send_bytes(64, -1);
    idle(1);
    send_preamble(); send_bytes(64, -1);
    idle(8);
    chk("t5b_eof",   32'(n_eof - e0), 2);
    chk("t5b_okcnt", 32'(n_ok - k0), 2);
    chk("t5b_valid", 32'(n_valid - v0), 128);

    // 6: reset mid-DATA, then a clean frame
    e0 = n_eof;
    send_preamble(); send_bytes(20, -1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_len", 32'(rx_len), 0);
    chk("t6_rst_ok",  32'(rx_crc_ok), 0);
    chk("t6_rst_flags", 32'({rx_valid, rx_sof, rx_eof}), 0);
    idle(2);
    rst = 1'b0;
    idle(4);
    chk("t6_no_eof", 32'(n_eof - e0), 0);
    v0 = n_valid; e0 = n_eof;
    send_preamble(); send_bytes(64, -1); idle(8);
    chk("t6_valid", 32'(n_valid - v0), 64);
    chk("t6_data",  32'(data_mism(v0, 64)), 0);
    chk("t6_eof",   32'(n_eof - e0), 1);
    chk("t6_ok",    32'(e_ok), 1);
    chk("t6_len",   32'(e_len), 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
